// File: rtl/acp_fifo_block_arbiter_if.sv
// Bundles the two ADC FIFO read ports, the packet sink port and the status flags
// that connect to acp_fifo_block_arbiter.
interface acp_fifo_block_arbiter_if #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 9
);
  logic              enable;
  logic [CNT_W-1:0]  ch0_count;
  logic [DATA_W-1:0] ch0_dout;
  logic              ch0_rd_en;
  logic [CNT_W-1:0]  ch1_count;
  logic [DATA_W-1:0] ch1_dout;
  logic              ch1_rd_en;
  logic              sink_ready;
  logic              pkt_valid;
  logic              pkt_first;
  logic              pkt_last;
  logic [DATA_W-1:0] pkt_data;
  logic              busy;
  logic              ovf;

  modport master (
    output enable, ch0_count, ch0_dout, ch1_count, ch1_dout, sink_ready,
    input  ch0_rd_en, ch1_rd_en, pkt_valid, pkt_first, pkt_last, pkt_data, busy, ovf
  );

  modport slave (
    input  enable, ch0_count, ch0_dout, ch1_count, ch1_dout, sink_ready,
    output ch0_rd_en, ch1_rd_en, pkt_valid, pkt_first, pkt_last, pkt_data, busy, ovf
  );
endinterface

// File: rtl/acp_fifo_block_arbiter.sv
// Drains whole blocks from two ADC sample FIFOs into one packet sink, one header
// word plus BLOCK_LEN samples per burst, with round-robin grant between channels.
module acp_fifo_block_arbiter #(
  parameter int DATA_W    = 16,
  parameter int CNT_W     = 9,
  parameter int BLOCK_LEN = 256,
  parameter int GAP_CYC   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  acp_fifo_block_arbiter_if.slave  bus
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_HDR   = 3'd1;
  localparam logic [2:0] ST_READ  = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;

  localparam int GAP_W = (GAP_CYC < 2) ? 1 : $clog2(GAP_CYC);

  localparam logic [CNT_W-1:0] BLOCK_THR = CNT_W'(BLOCK_LEN);
  localparam logic [CNT_W-1:0] READ_LAST = CNT_W'(BLOCK_LEN - 2);
  localparam logic [CNT_W-1:0] CNT_FULL  = '1;
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYC - 1);

  logic [2:0]        state;
  logic [2:0]        state_nxt;
  logic              sel;
  logic              last_grant;
  logic [11:0]       seq0;
  logic [11:0]       seq1;
  logic [CNT_W-1:0]  rd_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic              ovf_q;

  logic              avail0;
  logic              avail1;
  logic              start;
  logic              pick;
  logic [11:0]       seq_sel;
  logic [DATA_W-1:0] dout_sel;
  logic [DATA_W-1:0] hdr_word;

  logic              rd_en;
  logic              pkt_valid;
  logic              pkt_first;
  logic              pkt_last;
  logic [DATA_W-1:0] pkt_data;

  assign avail0 = bus.enable & (bus.ch0_count >= BLOCK_THR);
  assign avail1 = bus.enable & (bus.ch1_count >= BLOCK_THR);
  assign start  = bus.sink_ready & (avail0 | avail1);
  // A tie goes to the channel that did not win last time.
  assign pick   = (avail0 & avail1) ? ~last_grant : avail1;

  assign seq_sel  = sel ? seq1 : seq0;
  assign dout_sel = sel ? bus.ch1_dout : bus.ch0_dout;

  always_comb begin
    hdr_word             = '0;
    hdr_word[DATA_W-1]   = sel;
    hdr_word[11:0]       = seq_sel;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_HDR;
      ST_HDR:   state_nxt = ST_READ;
      ST_READ:  if (rd_cnt == READ_LAST) state_nxt = ST_DRAIN;
      ST_DRAIN: state_nxt = ST_GAP;
      ST_GAP:   if (gap_cnt == GAP_LAST) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      sel        <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && start) begin
        sel        <= pick;
        last_grant <= pick;
      end
    end
  end

  // READ runs BLOCK_LEN-1 cycles; the HDR cycle supplies the first FIFO read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt  <= '0;
      gap_cnt <= '0;
    end else begin
      if (state == ST_HDR) begin
        rd_cnt <= '0;
      end else if (state == ST_READ) begin
        rd_cnt <= rd_cnt + CNT_W'(1);
      end
      if (state == ST_DRAIN) begin
        gap_cnt <= '0;
      end else if (state == ST_GAP) begin
        gap_cnt <= gap_cnt + GAP_W'(1);
      end
    end
  end

  // Sequence numbers advance only on a completed packet; an aborted one keeps its number.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq0 <= '0;
      seq1 <= '0;
    end else if (state == ST_DRAIN) begin
      if (sel) begin
        seq1 <= seq1 + 12'd1;
      end else begin
        seq0 <= seq0 + 12'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (bus.ch0_count == CNT_FULL || bus.ch1_count == CNT_FULL) begin
      ovf_q <= 1'b1;
    end
  end

  // NOTE: every output gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    rd_en     = 1'b0;
    pkt_valid = 1'b0;
    pkt_first = 1'b0;
    pkt_last  = 1'b0;
    pkt_data  = '0;
    case (state)
      ST_HDR: begin
        rd_en     = 1'b1;
        pkt_valid = 1'b1;
        pkt_first = 1'b1;
        pkt_data  = hdr_word;
      end
      ST_READ: begin
        rd_en     = 1'b1;
        pkt_valid = 1'b1;
        pkt_data  = dout_sel;
      end
      ST_DRAIN: begin
        pkt_valid = 1'b1;
        pkt_last  = 1'b1;
        pkt_data  = dout_sel;
      end
      default: begin
      end
    endcase
  end

  // Outputs decode straight from state, so the async reset clears them at once.
  assign bus.ch0_rd_en = rd_en & ~sel;
  assign bus.ch1_rd_en = rd_en & sel;
  assign bus.pkt_valid = pkt_valid;
  assign bus.pkt_first = pkt_first;
  assign bus.pkt_last  = pkt_last;
  assign bus.pkt_data  = pkt_data;
  assign bus.busy      = (state != ST_IDLE);
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_acp_fifo_block_arbiter.sv
// Randomized bench for acp_fifo_block_arbiter: FIFO models feed both channels, a
// monitor scores every packet word against per-channel expected-data queues.
module tb_acp_fifo_block_arbiter;
  localparam int DATA_W    = 16;
  localparam int CNT_W     = 4;
  localparam int BLOCK_LEN = 4;
  localparam int GAP_CYC   = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  acp_fifo_block_arbiter_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  acp_fifo_block_arbiter #(
    .DATA_W(DATA_W), .CNT_W(CNT_W), .BLOCK_LEN(BLOCK_LEN), .GAP_CYC(GAP_CYC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int tests = 0;
  int fails = 0;
  int pkt_done = 0;
  int feed_prob [2];
  int fill_limit [2];

  logic [DATA_W-1:0] q0 [$];
  logic [DATA_W-1:0] q1 [$];
  logic [DATA_W-1:0] ed0 [$];
  logic [DATA_W-1:0] ed1 [$];
  logic [DATA_W-1:0] hdr_log [$];
  int                exp_ch [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  // FIFO models: rd_en seen during a cycle pops the head onto dout after the edge.
  initial begin : driver
    logic rd0, rd1;
    logic [DATA_W-1:0] w;
    bus.ch0_dout  = '0;
    bus.ch1_dout  = '0;
    bus.ch0_count = '0;
    bus.ch1_count = '0;
    forever begin
      @(negedge clk);
      rd0 = bus.ch0_rd_en;
      rd1 = bus.ch1_rd_en;
      @(posedge clk);
      #1;
      if (rst) begin
        q0.delete(); q1.delete(); ed0.delete(); ed1.delete();
        bus.ch0_dout = '0;
        bus.ch1_dout = '0;
      end else begin
        if (rd0) begin
          if (q0.size() == 0) check("fifo0_underflow", 0, 1);
          else bus.ch0_dout = q0.pop_front();
        end
        if (rd1) begin
          if (q1.size() == 0) check("fifo1_underflow", 0, 1);
          else bus.ch1_dout = q1.pop_front();
        end
        if (q0.size() < fill_limit[0] && $urandom_range(99) < feed_prob[0]) begin
          w = DATA_W'($urandom);
          q0.push_back(w);
          ed0.push_back(w);
        end
        if (q1.size() < fill_limit[1] && $urandom_range(99) < feed_prob[1]) begin
          w = DATA_W'($urandom);
          q1.push_back(w);
          ed1.push_back(w);
        end
      end
      bus.ch0_count = CNT_W'(q0.size());
      bus.ch1_count = CNT_W'(q1.size());
    end
  end

  // Packet-level checker, independent of stimulus timing.
  initial begin : monitor
    logic in_pkt, cur_ch, had_pkt, ch;
    int word_idx, rd_pkt, idle_run;
    logic [11:0] seq_m0, seq_m1;
    logic [DATA_W-1:0] exp_w;
    in_pkt = 1'b0; cur_ch = 1'b0; had_pkt = 1'b0;
    word_idx = 0; rd_pkt = 0; idle_run = 1000;
    seq_m0 = '0; seq_m1 = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_pkt = 1'b0; had_pkt = 1'b0; idle_run = 1000;
        seq_m0 = '0; seq_m1 = '0;
      end else begin
        check("rd_exclusive", bus.ch0_rd_en & bus.ch1_rd_en, 0);
        if (bus.pkt_valid && bus.pkt_first) begin
          check("hdr_inside_pkt", in_pkt, 0);
          if (had_pkt) check("gap_len", idle_run >= GAP_CYC + 1, 1);
          ch = bus.pkt_data[DATA_W-1];
          if (exp_ch.size() > 0) check("grant", ch, exp_ch.pop_front());
          check("hdr", bus.pkt_data, {ch, 3'b000, (ch ? seq_m1 : seq_m0)});
          check("hdr_last", bus.pkt_last, 0);
          hdr_log.push_back(bus.pkt_data);
          in_pkt = 1'b1; cur_ch = ch; word_idx = 0; rd_pkt = 0;
        end else if (bus.pkt_valid) begin
          check("valid_outside_pkt", in_pkt, 1);
          if (in_pkt) begin
            word_idx++;
            if (cur_ch ? (ed1.size() == 0) : (ed0.size() == 0)) begin
              check("exp_data_avail", 0, 1);
            end else begin
              exp_w = cur_ch ? ed1.pop_front() : ed0.pop_front();
              check("data", bus.pkt_data, exp_w);
            end
            check("last_flag", bus.pkt_last, word_idx == BLOCK_LEN);
            if (word_idx == BLOCK_LEN) begin
              check("rd_count", rd_pkt, BLOCK_LEN);
              if (cur_ch) seq_m1++;
              else seq_m0++;
              pkt_done++;
              in_pkt = 1'b0; had_pkt = 1'b1; idle_run = 0;
            end
          end
        end else begin
          check("idle_flags", {bus.pkt_first, bus.pkt_last}, 0);
          if (in_pkt) begin
            check("pkt_len", word_idx, BLOCK_LEN);
            in_pkt = 1'b0;
          end
          idle_run++;
        end
        if (bus.ch0_rd_en | bus.ch1_rd_en) begin
          if (!in_pkt) begin
            check("rd_outside_pkt", 1, 0);
          end else begin
            check("rd_chan", bus.ch1_rd_en, cur_ch);
            rd_pkt++;
          end
        end
        check("busy", bus.busy,
              bus.pkt_valid || (had_pkt && idle_run >= 1 && idle_run <= GAP_CYC));
      end
    end
  end

  task automatic do_reset();
    bus.enable = 1'b0;
    bus.sink_ready = 1'b0;
    fill_limit[0] = 0; fill_limit[1] = 0;
    feed_prob[0] = 100; feed_prob[1] = 100;
    exp_ch.delete();
    rst = 1'b1;
    repeat (3) tick();
    check("rst_outputs",
          {bus.pkt_valid, bus.pkt_first, bus.pkt_last, bus.ch0_rd_en, bus.ch1_rd_en,
           bus.busy, bus.ovf}, 0);
    check("rst_pkt_data", bus.pkt_data, 0);
    rst = 1'b0;
    tick();
  endtask

  task automatic wait_fill(input int ch, input int n);
    for (int i = 0; i < 200; i++) begin
      tick();
      if ((ch == 0 ? int'(bus.ch0_count) : int'(bus.ch1_count)) >= n) return;
    end
    check("fill_timeout", 1, 0);
  endtask

  task automatic wait_pkts(input int n, input int budget);
    int target;
    target = pkt_done + n;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (pkt_done >= target) return;
    end
    check("pkt_timeout", pkt_done, target);
  endtask

  task automatic wait_first(input int budget);
    for (int i = 0; i < budget; i++) begin
      tick();
      if (bus.pkt_first) return;
    end
    check("first_timeout", 0, 1);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got tests=%0d expected completion", tests);
    $fatal(1, "watchdog expired");
  end

  initial begin : control
    logic [DATA_W-1:0] exp_hdr [4];
    exp_hdr = '{16'h0000, 16'h8000, 16'h0001, 16'h8001};
    bus.enable = 1'b0;
    bus.sink_ready = 1'b0;
    fill_limit[0] = 0; fill_limit[1] = 0;
    feed_prob[0] = 100; feed_prob[1] = 100;

    // Round-robin with both channels continuously available.
    do_reset();
    fill_limit[0] = 12; fill_limit[1] = 12;
    bus.enable = 1'b1;
    wait_fill(0, 8);
    wait_fill(1, 8);
    hdr_log.delete();
    exp_ch.push_back(0); exp_ch.push_back(1); exp_ch.push_back(0); exp_ch.push_back(1);
    bus.sink_ready = 1'b1;
    wait_pkts(4, 200);
    check("t2_hdr_count", hdr_log.size() >= 4, 1);
    if (hdr_log.size() >= 4)
      for (int i = 0; i < 4; i++) check("t2_hdr_seq", hdr_log[i], exp_hdr[i]);

    // Single channel holding exactly one block.
    do_reset();
    fill_limit[0] = BLOCK_LEN;
    bus.enable = 1'b1;
    wait_fill(0, BLOCK_LEN);
    hdr_log.delete();
    exp_ch.push_back(0);
    bus.sink_ready = 1'b1;
    wait_pkts(1, 100);
    check("t1_hdr", hdr_log.size() > 0 ? hdr_log[0] : 16'hdead, 16'h0000);

    // sink_ready gate and one-cycle header latency.
    do_reset();
    fill_limit[1] = 8;
    bus.enable = 1'b1;
    wait_fill(1, 8);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t3_held_off", {bus.ch0_rd_en, bus.ch1_rd_en, bus.busy}, 0);
    end
    exp_ch.push_back(1);
    bus.sink_ready = 1'b1;
    tick();
    check("t3_hdr_first", bus.pkt_first, 1);
    check("t3_hdr_data", bus.pkt_data, 16'h8000);
    wait_pkts(1, 100);

    // Sequence number wrap on ch0.
    do_reset();
    fill_limit[0] = 12;
    bus.enable = 1'b1;
    bus.sink_ready = 1'b1;
    hdr_log.delete();
    wait_pkts(4097, 40000);
    check("t4_hdr_count", hdr_log.size() >= 4097, 1);
    if (hdr_log.size() >= 4097) begin
      check("t4_hdr_4095", hdr_log[4095], 16'h0FFF);
      check("t4_hdr_wrap", hdr_log[4096], 16'h0000);
    end

    // Reset in the middle of a ch0 packet.
    do_reset();
    fill_limit[0] = 12;
    bus.enable = 1'b1;
    bus.sink_ready = 1'b1;
    wait_first(100);
    tick();
    tick();
    check("t5_mid_pkt", {bus.pkt_valid, bus.ch0_rd_en}, 2'b11);
    rst = 1'b1;
    #1;
    check("t5_rst_outputs",
          {bus.pkt_valid, bus.pkt_first, bus.pkt_last, bus.ch0_rd_en, bus.ch1_rd_en, bus.busy}, 0);
    check("t5_rst_data", bus.pkt_data, 0);
    bus.sink_ready = 1'b0;
    exp_ch.delete();
    repeat (2) tick();
    rst = 1'b0;
    fill_limit[1] = 12;
    wait_fill(0, 8);
    wait_fill(1, 8);
    hdr_log.delete();
    exp_ch.push_back(0); exp_ch.push_back(1);
    bus.sink_ready = 1'b1;
    wait_pkts(2, 100);
    check("t5_hdr_count", hdr_log.size() >= 2, 1);
    if (hdr_log.size() >= 2) begin
      check("t5_hdr0", hdr_log[0], 16'h0000);
      check("t5_hdr1", hdr_log[1], 16'h8000);
    end

    // Randomized traffic with enable and sink_ready toggling.
    do_reset();
    fill_limit[0] = 12; fill_limit[1] = 12;
    bus.enable = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (i % 100 == 0) begin
        feed_prob[0] = int'($urandom_range(100));
        feed_prob[1] = int'($urandom_range(100));
      end
      if ($urandom_range(39) == 0) bus.enable = ~bus.enable;
      bus.sink_ready = ($urandom_range(3) != 0);
      tick();
    end
    bus.enable = 1'b0;
    for (int i = 0; i < 100 && bus.busy; i++) tick();
    check("rand_idle", bus.busy, 0);
    check("rand_no_ovf", bus.ovf, 0);

    // enable dropped mid-packet, then counter overflow flag.
    do_reset();
    fill_limit[0] = 12; fill_limit[1] = 12;
    bus.enable = 1'b1;
    bus.sink_ready = 1'b1;
    wait_first(100);
    tick();
    tick();
    bus.enable = 1'b0;
    wait_pkts(1, 50);
    repeat (GAP_CYC + 2) tick();
    for (int i = 0; i < 20; i++) begin
      tick();
      check("t6_no_new_pkt", {bus.pkt_valid, bus.busy}, 0);
    end
    fill_limit[1] = (1 << CNT_W) - 1;
    wait_fill(1, (1 << CNT_W) - 2);
    check("t6_ovf_before", bus.ovf, 0);
    wait_fill(1, (1 << CNT_W) - 1);
    tick();
    tick();
    check("t6_ovf_set", bus.ovf, 1);
    fill_limit[1] = 12;
    bus.enable = 1'b1;
    wait_pkts(3, 200);
    check("t6_ovf_sticky", bus.ovf, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
